// File: rtl/cv32e40p_ft_breakage_ctrl.sv
// cv32e40p_ft_breakage_ctrl: per-replica health counters and TMR->DEGRADED->FAILED reconfiguration for one TMR group
module cv32e40p_ft_breakage_ctrl #(
  parameter int unsigned INC_DEC_BIT = 2,
  parameter int unsigned COUNT_BIT = 8,
  parameter logic [INC_DEC_BIT-1:0] INCREMENT = 1,
  parameter logic [INC_DEC_BIT-1:0] DECREMENT = 1,
  parameter int unsigned BREAKING_THRESHOLD = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic [2:0]             err_i,
  input  logic                   clear_i,
  output logic [2:0]             broken_o,
  output logic [1:0]             mode_o,
  output logic [1:0]             sel_o,
  output logic                   fault_o,
  output logic                   event_o,
  output logic [3*COUNT_BIT-1:0] count_o
);
  typedef enum logic [1:0] {TMR = 2'b00, DEGRADED = 2'b01, FAILED = 2'b10} mode_t;
  localparam logic [COUNT_BIT:0] MAX = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [COUNT_BIT:0] INC = (COUNT_BIT+1)'(INCREMENT);
  localparam logic [COUNT_BIT:0] DEC = (COUNT_BIT+1)'(DECREMENT);
  mode_t mode_q;
  logic [COUNT_BIT-1:0] cnt_q [3];
  logic [COUNT_BIT-1:0] cnt_d [3];
  logic [2:0] brk_q, brk_d;
  logic [COUNT_BIT:0] sum, diff, upd;
  logic [1:0] nb, low;
  logic hard;
  always_comb begin
    sum = '0;
    diff = '0;
    upd = '0;
    cnt_d = cnt_q;
    brk_d = brk_q;
    for (int i = 0; i < 3; i++) begin
      sum = {1'b0, cnt_q[i]} + INC;
      diff = {1'b0, cnt_q[i]} - DEC;
      upd = err_i[i] ? (sum > MAX ? MAX : sum) : (diff[COUNT_BIT] ? '0 : diff);
      cnt_d[i] = (valid_i && !brk_q[i]) ? upd[COUNT_BIT-1:0] : cnt_q[i];
      brk_d[i] = brk_q[i] | (valid_i && (32'(cnt_d[i]) >= BREAKING_THRESHOLD));
    end
  end
  assign nb = {1'b0, brk_d[0]} + {1'b0, brk_d[1]} + {1'b0, brk_d[2]};
  assign low = brk_d[0] ? (brk_d[1] ? 2'd2 : 2'd1) : 2'd0;
  // broken replica's err bit is forced high, so all-ones means both healthy replicas disagree
  assign hard = valid_i && ((err_i | brk_q) == 3'b111);
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      cnt_q <= '{default: '0};
      brk_q <= '0;
      mode_q <= TMR;
      sel_o <= 2'd3;
      event_o <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      brk_q <= brk_d;
      event_o <= 1'b0;
      case (mode_q)
        TMR: begin
          if (nb >= 2'd2) begin
            mode_q <= FAILED;
            event_o <= 1'b1;
          end else if (nb == 2'd1) begin
            mode_q <= DEGRADED;
            sel_o <= low;
            event_o <= 1'b1;
          end
        end
        DEGRADED: begin
          if (nb >= 2'd2 || hard) begin
            mode_q <= FAILED;
            event_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign broken_o = brk_q;
  assign mode_o = mode_q;
  assign fault_o = mode_q == FAILED;
  assign count_o = {cnt_q[2], cnt_q[1], cnt_q[0]};
endmodule
